// File: rtl/ifu_fetch_queue_if.sv
// Fetch-group handshake bundle between the IFU writer, the fetch queue and decode.
// The queue takes the slave view; the writer/decode side drives through master.
interface ifu_fetch_queue_if #(
  parameter int unsigned INSTR_PER_FETCH = 4,
  parameter int unsigned ILEN            = 32,
  parameter int unsigned VLEN            = 32,
  parameter int unsigned DEPTH           = 4
);
  localparam int unsigned IW = INSTR_PER_FETCH * ILEN;
  localparam int unsigned CW = $clog2(DEPTH + 1);

  logic                       in_valid;
  logic                       in_ready;
  logic [VLEN-1:0]            in_pc;
  logic [IW-1:0]              in_instr;
  logic [INSTR_PER_FETCH-1:0] in_mask;
  logic                       out_valid;
  logic                       out_ready;
  logic [VLEN-1:0]            out_pc;
  logic [IW-1:0]              out_instr;
  logic [INSTR_PER_FETCH-1:0] out_mask;
  logic [CW-1:0]              count;

  modport master (
    output in_valid, in_pc, in_instr, in_mask, out_ready,
    input  in_ready, out_valid, out_pc, out_instr, out_mask, count
  );

  modport slave (
    input  in_valid, in_pc, in_instr, in_mask, out_ready,
    output in_ready, out_valid, out_pc, out_instr, out_mask, count
  );
endinterface

// File: rtl/ifu_fetch_queue.sv
// In-order fetch-group queue between IFU and decode, with optional empty-queue
// bypass and synchronous flush on redirect.
module ifu_fetch_queue #(
  parameter int unsigned INSTR_PER_FETCH = 4,
  parameter int unsigned ILEN            = 32,
  parameter int unsigned VLEN            = 32,
  parameter int unsigned DEPTH           = 4,
  parameter int unsigned BYPASS_EN       = 1
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            flush_i,
  ifu_fetch_queue_if.slave q
);
  localparam int unsigned IW  = INSTR_PER_FETCH * ILEN;
  localparam int unsigned CW  = $clog2(DEPTH + 1);
  localparam int unsigned PW  = $clog2(DEPTH);
  localparam bit          BYP = (BYPASS_EN != 0);

  typedef struct packed {
    logic [VLEN-1:0]            pc;
    logic [IW-1:0]              instr;
    logic [INSTR_PER_FETCH-1:0] mask;
  } entry_t;

  entry_t         mem [DEPTH];
  entry_t         head;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic           empty, any_mask, bypass, push, pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  // Handshake decode; in_ready looks only at registered occupancy, never at out_ready
  always_comb begin
    empty       = (count_q == '0);
    any_mask    = |q.in_mask;
    bypass      = BYP && !flush_i && empty && q.in_valid && any_mask;
    q.in_ready  = !flush_i && (count_q < CW'(DEPTH));
    q.out_valid = !flush_i && (!empty || bypass);
    pop         = q.out_valid && q.out_ready && !empty;
    push        = q.in_valid && q.in_ready && any_mask && !(bypass && q.out_ready);
  end

  // Head comes from storage when occupied, otherwise straight from the writer
  always_comb begin
    head = mem[rd_ptr_q];
    if (empty) begin
      head = '{pc: q.in_pc, instr: q.in_instr, mask: q.in_mask};
    end
    q.out_pc    = head.pc;
    q.out_instr = head.instr;
    q.out_mask  = head.mask;
    q.count     = count_q;
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    if (pop)  rd_ptr_d = next_ptr(rd_ptr_q);
    if (push) wr_ptr_d = next_ptr(wr_ptr_q);
    case ({push, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else if (flush_i) begin
      count_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
    end else begin
      count_q  <= count_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
    end
  end

  // Payload storage carries no reset; validity is tracked by count_q alone
  always_ff @(posedge clk_i) begin
    if (push) begin
      mem[wr_ptr_q] <= '{pc: q.in_pc, instr: q.in_instr, mask: q.in_mask};
    end
  end

  a_count_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
    count_q <= CW'(DEPTH));

  a_head_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
    (q.out_valid && !q.out_ready && !flush_i && !empty) |=> $stable(head));
endmodule

// File: doc/ifu_fetch_queue.md
Name: ifu_fetch_queue

Overview:
- Decoupling buffer between the ICache/IFU fetch path (writer) and the decode stage (reader).
- Stores whole fetch groups of INSTR_PER_FETCH instructions and delivers them to decode in order.
- Uses valid/ready handshakes on both sides.
- Supports an optional same-cycle empty-queue bypass (IFU_FETCHQ_BYPASS_EN) and a synchronous flush on redirect.

Parameters:
- INSTR_PER_FETCH, 4, instructions per fetch group.
- ILEN, 32, instruction width in bits.
- VLEN, 32, fetch-group PC width.
- DEPTH, 4, number of fetch-group entries (IFU_FQ_DEPTH); any value >= 2, need not be a power of two.
- BYPASS_EN, 1, 1 = empty-queue combinational bypass enabled (IFU_FETCHQ_BYPASS_EN).

Ports:
- clk_i  in  1  clock; all state updates on the rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- flush_i  in  1  synchronous flush (redirect/mispredict).
- in_valid_i  in  1  writer has a fetch group.
- in_ready_o  out  1  queue accepts a group this cycle.
- in_pc_i  in  VLEN  PC of slot 0.
- in_instr_i  in  INSTR_PER_FETCH*ILEN  instructions; slot k at bits [k*ILEN +: ILEN].
- in_mask_i  in  INSTR_PER_FETCH  per-slot valid mask.
- out_valid_o  out  1  group available to decode.
- out_ready_i  in  1  decode consumes the group.
- out_pc_o  out  VLEN  head group PC.
- out_instr_o  out  INSTR_PER_FETCH*ILEN  head group instructions.
- out_mask_o  out  INSTR_PER_FETCH  head group mask.
- count_o  out  $clog2(DEPTH+1)  occupied entries.

Behaviour:
- Reset (rst_ni=0, asynchronous): count=0, rd_ptr=0, wr_ptr=0. out_valid_o=0, count_o=0, in_ready_o=1 once reset is released. Storage array is not reset; out_* data is don't-care while out_valid_o=0.
- in_ready_o = !flush_i && (count < DEPTH). It is registered-state-driven and does not depend on out_ready_i, so a full queue does not accept a group in the same cycle it is popped.
- bypass = BYPASS_EN && !flush_i && count==0 && in_valid_i && in_mask_i!=0.
- out_valid_o = !flush_i && (count!=0 || bypass).
- Output data comes from entry[rd_ptr] when count!=0, otherwise from the in_* ports (bypass path).
- pop = out_valid_o && out_ready_i && count!=0.
  - rd_ptr advances: rd_ptr==DEPTH-1 wraps to 0, otherwise increments by 1.
- push = in_valid_i && in_ready_o && in_mask_i!=0 && !(bypass && out_ready_i).
  - Writes entry[wr_ptr] and advances wr_ptr with the same wrap rule.
- A bypassed group consumed by decode is never written; count is unchanged.
- If bypass is offered (out_valid_o=1) but out_ready_i=0, the group is pushed normally. Decode sees it from storage in the next cycle.
- Zero-mask group (in_mask_i==0) with in_ready_o=1 is accepted (handshake completes) and discarded. No push, no bypass.
- count_next = count + push - pop. Simultaneous push and pop leaves count unchanged and preserves FIFO order. count never exceeds DEPTH and never underflows.
- flush_i=1:
  - Both handshakes are suppressed in that cycle (in_ready_o=0, out_valid_o=0).
  - Next cycle: count=0, rd_ptr=0, wr_ptr=0.
  - Flush has priority over any push or pop in the same cycle.
- BYPASS_EN=0: a group written into an empty queue becomes visible at out_* one cycle after acceptance (minimum latency 1). With BYPASS_EN=1 the minimum latency is 0.
- Assertions (sim only):
  - count <= DEPTH.
  - out_* stable while out_valid_o && !out_ready_i && !flush_i && count!=0.

Test Plan:
- Reset: hold rst_ni=0 for 3 cycles, then release -> out_valid_o=0, count_o=0, in_ready_o=1 in the first cycle after release.
- Bypass: empty queue, in_valid_i=1, in_pc_i=0x8000_0000, mask 4'b1111, out_ready_i=1 -> same cycle out_valid_o=1, out_pc_o=0x8000_0000; count_o stays 0.
- Fill/drain: out_ready_i=0, push PCs 0x1000, 0x1010, 0x1020, 0x1030 -> count_o=4, in_ready_o=0, fifth group (0x1040) held. Then raise out_ready_i=1:
  - pops return 0x1000..0x1030 in order;
  - 0x1040 is accepted in the cycle after the first pop.
- Wrap/simultaneous: with count=2, drive push and pop every cycle for 6 cycles (PCs 0x2000+0x10*n) -> count_o stays 2; outputs appear in push order across the pointer wrap (DEPTH=4). Repeat with DEPTH=3 to check non-power-of-two wrap.
- Flush: count=3, in_valid_i=1, out_ready_i=1, flush_i=1 for 1 cycle -> that cycle out_valid_o=0, in_ready_o=0; next cycle count_o=0, out_valid_o=0, and the flushed-cycle input is not stored.
- Zero mask and no bypass:
  - Empty queue, push with mask 4'b0000 -> accepted, count_o stays 0, out_valid_o=0.
  - With BYPASS_EN=0, push PC 0x3000 into an empty queue -> out_valid_o=1 with out_pc_o=0x3000 exactly one cycle later.
